// File: rtl/ccd_pkg.sv
// Shared definitions for the TCD1209D capture path: line-state encoding,
// default line geometry and a counter-width helper.
package ccd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } ccd_state_e;

  localparam int unsigned CCD_DW         = 12;
  localparam int unsigned CCD_PXL_TOTAL  = 2100;
  localparam int unsigned CCD_OB_START   = 16;
  localparam int unsigned CCD_OB_LOG2    = 3;
  localparam int unsigned CCD_ACT_START  = 32;
  localparam int unsigned CCD_ACT_NUM    = 2048;
  localparam int unsigned CCD_SAMPLE_DLY = 5;
  localparam int unsigned CCD_TIMEOUT    = 1023;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned ccd_cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccd_dark_level.sv
// Per-line dark level from the optical-black window.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   sample             : latched ADC word for the current sample event
//   idx                : pixel index of that sample
//   sample_stb         : one-cycle strobe, sample/idx are valid
//   line_clr           : clears the accumulator at the start of a line
//   dark_level         : mean of the OB samples, held until the next update
module ccd_dark_level
  import ccd_pkg::*;
#(
  parameter int unsigned DW       = CCD_DW,
  parameter int unsigned IW       = 12,
  parameter int unsigned OB_START = CCD_OB_START,
  parameter int unsigned OB_LOG2  = CCD_OB_LOG2
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] sample,
  input  logic [IW-1:0] idx,
  input  logic          sample_stb,
  input  logic          line_clr,
  output logic [DW-1:0] dark_level
);

  localparam int unsigned AW      = DW + OB_LOG2;
  localparam int unsigned OB_LAST = OB_START + (1 << OB_LOG2) - 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] sum_c;
  logic          in_ob_c;
  logic          ob_last_c;

  assign in_ob_c   = sample_stb && (idx >= IW'(OB_START)) && (idx <= IW'(OB_LAST));
  assign ob_last_c = in_ob_c && (idx == IW'(OB_LAST));
  assign sum_c     = acc + AW'(sample);

  // Accumulator; the final OB sample is folded in combinationally so the
  // level is ready one cycle after that sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc        <= '0;
      dark_level <= '0;
    end else begin
      if (line_clr) begin
        acc <= '0;
      end else if (in_ob_c) begin
        acc <= sum_c;
      end
      if (ob_last_c) begin
        dark_level <= DW'(sum_c >> OB_LOG2);
      end
    end
  end

endmodule

// File: rtl/tcd1209d_capture.sv
// Receive side of the TCD1209D driver: frames lines with sh, samples the
// ADC a fixed delay after each cp falling edge, measures the OB dark level
// and streams dark-subtracted active pixels.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   sh, cp             : transfer-gate and clamp pulses from the driver
//   adc_data           : ADC word, stable around the latch point
//   pxl_data/valid     : active pixel stream (no backpressure)
//   pxl_sof, pxl_eol   : first / last active pixel markers
//   dark_level         : current line dark level
//   line_done          : pulse after a complete line
//   err_short          : pulse when sh aborts a line
//   err_timeout        : pulse when sample events stop mid-line
module tcd1209d_capture
  import ccd_pkg::*;
#(
  parameter int unsigned DW         = CCD_DW,
  parameter int unsigned PXL_TOTAL  = CCD_PXL_TOTAL,
  parameter int unsigned OB_START   = CCD_OB_START,
  parameter int unsigned OB_LOG2    = CCD_OB_LOG2,
  parameter int unsigned ACT_START  = CCD_ACT_START,
  parameter int unsigned ACT_NUM    = CCD_ACT_NUM,
  parameter int unsigned SAMPLE_DLY = CCD_SAMPLE_DLY,
  parameter int unsigned TIMEOUT    = CCD_TIMEOUT,
  parameter bit          DARK_SUB   = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          sh,
  input  logic          cp,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] pxl_data,
  output logic          pxl_valid,
  output logic          pxl_sof,
  output logic          pxl_eol,
  output logic [DW-1:0] dark_level,
  output logic          line_done,
  output logic          err_short,
  output logic          err_timeout
);

  localparam int unsigned IW       = ccd_cnt_w(PXL_TOTAL - 1);
  localparam int unsigned DLW      = ccd_cnt_w(SAMPLE_DLY);
  localparam int unsigned TW       = ccd_cnt_w(TIMEOUT);
  localparam int unsigned ACT_LAST = ACT_START + ACT_NUM - 1;

  ccd_state_e     state, state_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [TW-1:0]  to_cnt, to_cnt_nxt;
  logic [DLW-1:0] dly_cnt;
  logic           sh_q, cp_q;

  logic           sh_rise_c, sh_fall_c, cp_fall_c, sample_ev_c;
  logic           stb_c, line_clr_c, act_c;
  logic           line_done_nxt, err_short_nxt, err_timeout_nxt;
  logic [DW:0]    diff_c;
  logic [DW-1:0]  pix_c;

  assign sh_rise_c = sh & ~sh_q;
  assign sh_fall_c = ~sh & sh_q;
  assign cp_fall_c = ~cp & cp_q;

  // Edge-detect history.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_q <= 1'b0;
      cp_q <= 1'b0;
    end else begin
      sh_q <= sh;
      cp_q <= cp;
    end
  end

  // Sample-point delay: a fresh cp fall reloads, an event fires when the
  // count expires at 1 (a reload on that same cycle wins).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dly_cnt <= '0;
    end else if (cp_fall_c) begin
      dly_cnt <= DLW'(SAMPLE_DLY);
    end else if (dly_cnt != '0) begin
      dly_cnt <= dly_cnt - DLW'(1);
    end
  end

  assign sample_ev_c = (SAMPLE_DLY == 0) ? cp_fall_c
                                         : (!cp_fall_c && (dly_cnt == DLW'(1)));

  // Line state, pixel index and inter-sample timeout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      to_cnt      <= '0;
      line_done   <= 1'b0;
      err_short   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      to_cnt      <= to_cnt_nxt;
      line_done   <= line_done_nxt;
      err_short   <= err_short_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    to_cnt_nxt      = to_cnt;
    stb_c           = 1'b0;
    line_clr_c      = 1'b0;
    line_done_nxt   = 1'b0;
    err_short_nxt   = 1'b0;
    err_timeout_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sh_rise_c) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (sh_fall_c) begin
          state_nxt  = ST_CAPTURE;
          idx_nxt    = '0;
          to_cnt_nxt = '0;
          line_clr_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // sh has priority: a coincident sample is dropped.
        if (sh_rise_c) begin
          err_short_nxt = 1'b1;
          state_nxt     = ST_ARM;
        end else if (sample_ev_c) begin
          stb_c      = 1'b1;
          to_cnt_nxt = '0;
          if (idx == IW'(PXL_TOTAL - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      ST_DONE: begin
        line_done_nxt = 1'b1;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Active-window pixel, dark-subtracted with a borrow bit for saturation.
  assign act_c  = stb_c && (idx >= IW'(ACT_START)) && (idx <= IW'(ACT_LAST));
  assign diff_c = {1'b0, adc_data} - {1'b0, dark_level};
  assign pix_c  = !DARK_SUB ? adc_data : (diff_c[DW] ? '0 : diff_c[DW-1:0]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pxl_data  <= '0;
      pxl_valid <= 1'b0;
      pxl_sof   <= 1'b0;
      pxl_eol   <= 1'b0;
    end else begin
      pxl_valid <= act_c;
      pxl_sof   <= act_c && (idx == IW'(ACT_START));
      pxl_eol   <= act_c && (idx == IW'(ACT_LAST));
      if (act_c) pxl_data <= pix_c;
    end
  end

  ccd_dark_level #(
    .DW       (DW),
    .IW       (IW),
    .OB_START (OB_START),
    .OB_LOG2  (OB_LOG2)
  ) u_dark (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sample     (adc_data),
    .idx        (idx),
    .sample_stb (stb_c),
    .line_clr   (line_clr_c),
    .dark_level (dark_level)
  );

endmodule

// File: tb/tb_tcd1209d_capture.sv
`timescale 1ns/1ps
module tb_tcd1209d_capture;

  localparam int DW        = 12;
  localparam int PXL_TOTAL = 2100;
  localparam int OB_START  = 16;
  localparam int OB_N      = 8;
  localparam int ACT_START = 32;
  localparam int ACT_LAST  = 2079;

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [DW-1:0] data;
  } beat_t;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          sh        = 1'b0;
  logic          cp        = 1'b0;
  logic [DW-1:0] adc_data  = '0;

  logic [DW-1:0] d_data, d_dark, r_data, r_dark;
  logic          d_valid, d_sof, d_eol, d_done, d_es, d_et;
  logic          r_valid, r_sof, r_eol, r_done, r_es, r_et;

  tcd1209d_capture #(.SAMPLE_DLY(5), .TIMEOUT(1023), .DARK_SUB(1'b1)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sh(sh), .cp(cp), .adc_data(adc_data),
    .pxl_data(d_data), .pxl_valid(d_valid), .pxl_sof(d_sof), .pxl_eol(d_eol),
    .dark_level(d_dark), .line_done(d_done), .err_short(d_es), .err_timeout(d_et));

  tcd1209d_capture #(.SAMPLE_DLY(5), .TIMEOUT(1023), .DARK_SUB(1'b0)) u_raw (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sh(sh), .cp(cp), .adc_data(adc_data),
    .pxl_data(r_data), .pxl_valid(r_valid), .pxl_sof(r_sof), .pxl_eol(r_eol),
    .dark_level(r_dark), .line_done(r_done), .err_short(r_es), .err_timeout(r_et));

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  beat_t q_dut[$];
  beat_t q_raw[$];

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // Monitor-side observations.
  int valid_cnt = 0, sof_cnt = 0, eol_cnt = 0, ld_cnt = 0, es_cnt = 0, et_cnt = 0;
  int raw_ld_cnt = 0, raw_es_cnt = 0, raw_et_cnt = 0;
  int first_data = -1, last_data = -1, raw_first = -1, raw_last = -1;
  int last_valid_cyc = 0, et_cyc = 0;

  // Bench model state.
  int idx_m = 0, ob_sum = 0, dark_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  beat_t e_d, e_r;
  always @(negedge sys_clk) begin
    if (d_valid) begin
      if (q_dut.size() == 0) check("dut_unexpected_valid", 32'd1, 32'd0);
      else begin
        e_d = q_dut.pop_front();
        check("dut_pxl_data", 32'(d_data), 32'(e_d.data));
        check("dut_pxl_sof", 32'(d_sof), 32'(e_d.sof));
        check("dut_pxl_eol", 32'(d_eol), 32'(e_d.eol));
      end
      valid_cnt++;
      last_valid_cyc = cyc;
      if (d_sof) begin sof_cnt++; first_data = int'(d_data); end
      if (d_eol) begin eol_cnt++; last_data = int'(d_data); end
    end
    if (r_valid) begin
      if (q_raw.size() == 0) check("raw_unexpected_valid", 32'd1, 32'd0);
      else begin
        e_r = q_raw.pop_front();
        check("raw_pxl_data", 32'(r_data), 32'(e_r.data));
        check("raw_pxl_sof", 32'(r_sof), 32'(e_r.sof));
        check("raw_pxl_eol", 32'(r_eol), 32'(e_r.eol));
      end
      if (r_sof) raw_first = int'(r_data);
      if (r_eol) raw_last = int'(r_data);
    end
    if (d_done) ld_cnt++;
    if (d_es)   es_cnt++;
    if (d_et)   begin et_cnt++; et_cyc = cyc; end
    if (r_done) raw_ld_cnt++;
    if (r_es)   raw_es_cnt++;
    if (r_et)   raw_et_cnt++;
  end

  // sh pulse: rising edge arms (or aborts a capture), falling edge starts a line.
  task automatic start_line();
    @(negedge sys_clk); cp = 1'b0; sh = 1'b1;
    repeat (3) @(negedge sys_clk);
    sh = 1'b0;
    repeat (3) @(negedge sys_clk);
    idx_m  = 0;
    ob_sum = 0;
  endtask

  // One pixel period of 7 clocks. The sample event lands 5 clocks after
  // the cp fall is seen; adc_data carries 0xAAA until exactly that cycle.
  task automatic pixel(input logic [DW-1:0] val, input bit capt);
    beat_t e;
    @(negedge sys_clk); cp = 1'b1; adc_data = 12'hAAA;
    @(negedge sys_clk); cp = 1'b0;
    repeat (4) @(negedge sys_clk);
    @(negedge sys_clk); adc_data = val;
    if (capt) begin
      if (idx_m >= OB_START && idx_m < OB_START + OB_N) begin
        ob_sum += int'(val);
        if (idx_m == OB_START + OB_N - 1) dark_m = ob_sum / OB_N;
      end
      if (idx_m >= ACT_START && idx_m <= ACT_LAST) begin
        e.sof  = (idx_m == ACT_START);
        e.eol  = (idx_m == ACT_LAST);
        e.data = (int'(val) > dark_m) ? DW'(int'(val) - dark_m) : '0;
        q_dut.push_back(e);
        e.data = val;
        q_raw.push_back(e);
      end
      idx_m++;
    end
  endtask

  // OB window gets ob_val; other pixels get base (+idx when ramp).
  task automatic run_samples(input int n, input int ob_val, input int base, input bit ramp);
    int v;
    for (int i = 0; i < n; i++) begin
      v = (i >= OB_START && i < OB_START + OB_N) ? ob_val : (ramp ? base + i : base);
      pixel(DW'(v), 1'b1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pxl_valid"},   32'(d_valid), 32'd0);
    check({tag, "_pxl_data"},    32'(d_data),  32'd0);
    check({tag, "_pxl_sof"},     32'(d_sof),   32'd0);
    check({tag, "_pxl_eol"},     32'(d_eol),   32'd0);
    check({tag, "_dark_level"},  32'(d_dark),  32'd0);
    check({tag, "_line_done"},   32'(d_done),  32'd0);
    check({tag, "_err_short"},   32'(d_es),    32'd0);
    check({tag, "_err_timeout"}, 32'(d_et),    32'd0);
    check({tag, "_raw_valid"},   32'(r_valid), 32'd0);
    check({tag, "_raw_data"},    32'(r_data),  32'd0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base_v;
    // Reset state
    repeat (3) @(negedge sys_clk);
    check_zero_outputs("reset");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Nominal line: OB = 40, pixels 100+idx
    base_v = valid_cnt;
    start_line();
    run_samples(PXL_TOTAL, 40, 100, 1'b1);
    repeat (6) @(negedge sys_clk);
    check("nom_dark_level", 32'(d_dark), 32'd40);
    check("nom_valid_count", 32'(valid_cnt - base_v), 32'd2048);
    check("nom_first_data", 32'(first_data), 32'd92);     // 100+32-40
    check("nom_last_data", 32'(last_data), 32'd2139);     // 100+2079-40
    check("nom_sof_count", 32'(sof_cnt), 32'd1);
    check("nom_eol_count", 32'(eol_cnt), 32'd1);
    check("nom_line_done", 32'(ld_cnt), 32'd1);

    // Short line: OB = 60, aborted by sh after 1000 samples
    start_line();
    run_samples(1000, 60, 100, 1'b1);
    start_line();
    check("short_err_short", 32'(es_cnt), 32'd1);
    check("short_no_line_done", 32'(ld_cnt), 32'd1);
    check("short_no_eol", 32'(eol_cnt), 32'd1);
    check("short_dark_held", 32'(d_dark), 32'd60);

    // Following full line is the saturation line: OB 500, rest 300
    base_v = valid_cnt;
    run_samples(PXL_TOTAL, 500, 300, 1'b0);
    repeat (6) @(negedge sys_clk);
    check("sat_dark_level", 32'(d_dark), 32'd500);
    check("sat_valid_count", 32'(valid_cnt - base_v), 32'd2048);
    check("sat_first_data", 32'(first_data), 32'd0);
    check("sat_last_data", 32'(last_data), 32'd0);
    check("sat_raw_first", 32'(raw_first), 32'd300);
    check("sat_raw_last", 32'(raw_last), 32'd300);
    check("sat_line_done", 32'(ld_cnt), 32'd2);
    check("sat_eol_count", 32'(eol_cnt), 32'd2);

    // Timeout: 200 samples of 0x555 (pre-latch value 0xAAA), then cp stops
    start_line();
    run_samples(200, 'h555, 'h555, 1'b0);
    for (int i = 0; i < 1200 && et_cnt == 0; i++) @(negedge sys_clk);
    check("to_err_timeout", 32'(et_cnt), 32'd1);
    check("to_delay", 32'(et_cyc - last_valid_cyc), 32'd1023);
    check("to_dark_level", 32'(d_dark), 32'h555);
    check("to_raw_sample_point", 32'(r_data), 32'h555);
    check("to_no_line_done", 32'(ld_cnt), 32'd2);
    // Back in IDLE: cp activity without sh must produce nothing
    base_v = valid_cnt;
    for (int i = 0; i < 40; i++) pixel(DW'(i), 1'b0);
    repeat (4) @(negedge sys_clk);
    check("idle_no_valid", 32'(valid_cnt - base_v), 32'd0);
    check("idle_err_timeout", 32'(et_cnt), 32'd1);

    // Reset mid-line at sample 1500
    start_line();
    run_samples(1500, 40, 100, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    check("midrst_queue_empty", 32'(q_dut.size()), 32'd0);
    dark_m = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    base_v = valid_cnt;
    start_line();
    run_samples(PXL_TOTAL, 40, 100, 1'b1);
    repeat (6) @(negedge sys_clk);
    check("post_rst_valid_count", 32'(valid_cnt - base_v), 32'd2048);
    check("post_rst_first_data", 32'(first_data), 32'd92);
    check("post_rst_last_data", 32'(last_data), 32'd2139);
    check("post_rst_dark_level", 32'(d_dark), 32'd40);
    check("post_rst_line_done", 32'(ld_cnt), 32'd3);
    check("post_rst_eol_count", 32'(eol_cnt), 32'd3);

    // Totals
    check("total_err_short", 32'(es_cnt), 32'd1);
    check("total_err_timeout", 32'(et_cnt), 32'd1);
    check("raw_line_done", 32'(raw_ld_cnt), 32'd3);
    check("raw_err_short", 32'(raw_es_cnt), 32'd1);
    check("raw_err_timeout", 32'(raw_et_cnt), 32'd1);
    check("raw_dark_level", 32'(r_dark), 32'd40);
    check("dut_queue_drained", 32'(q_dut.size()), 32'd0);
    check("raw_queue_drained", 32'(q_raw.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
